// File: rtl/bufreg_rr_arbiter.sv
// Round-robin arbiter sharing one two-word buffer register among NUM_REQ cores.
// Define BUFARB_STATS_EN to add wr_count / conflict_count statistics outputs.
module bufreg_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_d1,
  input  logic [NUM_REQ*DATA_W-1:0]    req_d2,
  input  logic                         stall,
  input  logic                         buf_ack,
  output logic [NUM_REQ-1:0]           grant,
  output logic [DATA_W-1:0]            out_1,
  output logic [DATA_W-1:0]            out_2,
  output logic                         flag,
  output logic [$clog2(NUM_REQ)-1:0]   owner
`ifdef BUFARB_STATS_EN
  ,
  output logic [31:0]                  wr_count,
  output logic [31:0]                  conflict_count
`endif
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0]   out1_q, out1_d, out2_q, out2_d;
  logic [ID_W-1:0]     owner_q, owner_d, last_q, last_d;

  logic [NUM_REQ-1:0]  elig;
  logic [ID_W-1:0]     pick, idx_w;
  logic                found, cap;
  int                  idx;

  // A core whose grant is showing is masked so its held req is not taken twice.
  assign elig = req & ~grant_q;
  assign cap  = (|elig) & ~stall & ((state_q == EMPTY) | buf_ack);

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (!found && elig[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    out1_d  = out1_q;
    out2_d  = out2_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (cap) begin
      out1_d  = req_d1[int'(pick)*DATA_W +: DATA_W];
      out2_d  = req_d2[int'(pick)*DATA_W +: DATA_W];
      owner_d = pick;
      last_d  = pick;
      grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
    end
    case (state_q)
      EMPTY:   if (cap) state_d = FULL;
      FULL:    if (buf_ack && !cap) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= EMPTY;
      grant_q <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      owner_q <= '0;
      last_q  <= ID_W'(NUM_REQ-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign grant = grant_q;
  assign out_1 = out1_q;
  assign out_2 = out2_q;
  assign flag  = (state_q == FULL);
  assign owner = owner_q;

`ifdef BUFARB_STATS_EN
  logic [31:0] wr_q, wr_d, conf_q, conf_d;

  // More than one eligible core is a conflict whether or not a capture happens.
  always_comb begin
    wr_d   = cap ? wr_q + 32'd1 : wr_q;
    conf_d = ($countones(elig) > 1) ? conf_q + 32'd1 : conf_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_q   <= '0;
      conf_q <= '0;
    end else begin
      wr_q   <= wr_d;
      conf_q <= conf_d;
    end
  end

  assign wr_count       = wr_q;
  assign conflict_count = conf_q;
`endif
endmodule

// File: tb/tb_bufreg_rr_arbiter.sv
// Directed self-checking bench for bufreg_rr_arbiter (NUM_REQ=4, DATA_W=32).
module tb_bufreg_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_d1, req_d2;
  logic             stall, buf_ack;
  logic [NR-1:0]    grant;
  logic [DW-1:0]    out_1, out_2;
  logic             flag;
  logic [1:0]       owner;
`ifdef BUFARB_STATS_EN
  logic [31:0]      wr_count, conflict_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  bufreg_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_d1(req_d1), .req_d2(req_d2),
    .stall(stall), .buf_ack(buf_ack), .grant(grant), .out_1(out_1), .out_2(out_2),
    .flag(flag), .owner(owner)
`ifdef BUFARB_STATS_EN
    , .wr_count(wr_count), .conflict_count(conflict_count)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic f, input logic [3:0] g,
                           input logic [1:0] o, input logic [31:0] w1, input logic [31:0] w2);
    chk({tag, ".flag"},  {31'd0, flag}, {31'd0, f});
    chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, ".owner"}, {30'd0, owner}, {30'd0, o});
    chk({tag, ".out_1"}, out_1, w1);
    chk({tag, ".out_2"}, out_2, w2);
  endtask

  initial begin
    Reset = 1'b1; req = '0; req_d1 = '0; req_d2 = '0; stall = 1'b0; buf_ack = 1'b0;
    tick();
    Reset = 1'b0;
    chk_state("reset", 1'b0, 4'b0000, 2'd0, 32'h0, 32'h0);

    // 1) single capture from core 0
    req = 4'b0001; req_d1[31:0] = 32'hA; req_d2[31:0] = 32'hB;
    tick();
    chk_state("t1.cap", 1'b1, 4'b0001, 2'd0, 32'hA, 32'hB);
    req = '0;
    tick();
    chk_state("t1.hold", 1'b1, 4'b0000, 2'd0, 32'hA, 32'hB);

    // 2) all cores requesting, consumer acks every cycle
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_d1[i*DW +: DW] = 32'h100 + 32'(i);
      req_d2[i*DW +: DW] = 32'h200 + 32'(i);
    end
    req = 4'b1111; buf_ack = 1'b1;
    tick(); chk_state("t2.c0", 1'b1, 4'b0001, 2'd0, 32'h100, 32'h200);
    tick(); chk_state("t2.c1", 1'b1, 4'b0010, 2'd1, 32'h101, 32'h201);
    tick(); chk_state("t2.c2", 1'b1, 4'b0100, 2'd2, 32'h102, 32'h202);
    tick(); chk_state("t2.c3", 1'b1, 4'b1000, 2'd3, 32'h103, 32'h203);
    tick(); chk_state("t2.c0b", 1'b1, 4'b0001, 2'd0, 32'h100, 32'h200);
`ifdef BUFARB_STATS_EN
    tick(); tick(); tick();
    chk("t6.wr_count", wr_count, 32'd8);
    chk("t6.conflict_count", conflict_count, 32'd8);
`endif

    // 3) full from core 2, core 0 waits without ack
    req = '0; buf_ack = 1'b0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    req = 4'b0100;
    tick(); chk_state("t3.c2", 1'b1, 4'b0100, 2'd2, 32'h102, 32'h202);
    req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick(); chk_state("t3.wait", 1'b1, 4'b0000, 2'd2, 32'h102, 32'h202);
    end
    buf_ack = 1'b1;
    tick(); chk_state("t3.handoff", 1'b1, 4'b0001, 2'd0, 32'h100, 32'h200);
    req = '0;
    tick(); chk_state("t3.drain", 1'b0, 4'b0000, 2'd0, 32'h100, 32'h200);

    // 4) stall blocks capture while empty, then releases
    buf_ack = 1'b0; stall = 1'b1; req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick(); chk_state("t4.stall", 1'b0, 4'b0000, 2'd0, 32'h100, 32'h200);
    end
    stall = 1'b0;
    tick(); chk_state("t4.cap", 1'b1, 4'b0010, 2'd1, 32'h101, 32'h201);
    req = 4'b0001; stall = 1'b1; buf_ack = 1'b1;
    tick(); chk_state("t4.stall_ack", 1'b0, 4'b0000, 2'd1, 32'h101, 32'h201);
    req = '0; stall = 1'b0;
    tick(); chk_state("t4.ack_empty", 1'b0, 4'b0000, 2'd1, 32'h101, 32'h201);

    // 5) held req through grant is masked; reset mid-FULL
    req = 4'b1000;
    tick(); chk_state("t5.c3", 1'b1, 4'b1000, 2'd3, 32'h103, 32'h203);
    tick(); chk_state("t5.mask", 1'b0, 4'b0000, 2'd3, 32'h103, 32'h203);
    req = 4'b0100; buf_ack = 1'b0;
    tick(); chk_state("t5.c2", 1'b1, 4'b0100, 2'd2, 32'h102, 32'h202);
    req = 4'b1111; Reset = 1'b1;
    tick(); chk_state("t5.reset", 1'b0, 4'b0000, 2'd0, 32'h0, 32'h0);
    Reset = 1'b0;
    tick(); chk_state("t5.first", 1'b1, 4'b0001, 2'd0, 32'h100, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
